// File: rtl/wb_stage_arb.sv
// Write-back stage: MEM->WB pipeline register, load-data formatting, and a
// single register-file write port shared between the in-order pipeline and a
// buffered long-latency result FIFO (divider/FPU). Also provides forwarding
// outputs and an instruction-retire counter.
module wb_stage_arb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NBANKS   = 2,
  parameter int LL_DEPTH = 4,
  parameter int CNT_W    = 64,
  localparam int BANK_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int PTR_W   = $clog2(LL_DEPTH),
  localparam int CNT_LW  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_mem_i,
  input  logic [ADDR_W-1:0] rd_addr_mem_i,
  input  logic [BANK_W-1:0] rd_bank_mem_i,
  input  logic [DATA_W-1:0] alu_result_mem_i,
  input  logic [DATA_W-1:0] mem_rdata_mem_i,
  input  logic [1:0]        mem_size_mem_i,
  input  logic              mem_unsigned_mem_i,
  input  logic [1:0]        mem_offset_mem_i,
  input  logic              reg_alu_wen_mem_i,
  input  logic              reg_mem_wen_mem_i,
  input  logic              stall_wb_i,
  input  logic              flush_wb_i,
  input  logic              ll_valid_i,
  output logic              ll_ready_o,
  input  logic [ADDR_W-1:0] ll_rd_addr_i,
  input  logic [BANK_W-1:0] ll_rd_bank_i,
  input  logic [DATA_W-1:0] ll_wdata_i,
  output logic [NBANKS-1:0] reg_wen_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              hold_req_o,
  output logic [ADDR_W-1:0] rd_addr_wb_o,
  output logic [BANK_W-1:0] rd_bank_wb_o,
  output logic [DATA_W-1:0] wdata_wb_o,
  output logic              wen_wb_o,
  output logic [CNT_LW-1:0] ll_count_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  instret_o
);

  localparam logic [CNT_LW-1:0] DEPTH_C = CNT_LW'(LL_DEPTH);

  // WB pipeline register
  logic              wb_valid, wb_alu_wen, wb_mem_wen, wb_unsigned, wb_committed;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [BANK_W-1:0] wb_rd_bank;
  logic [DATA_W-1:0] wb_alu_result, wb_rdata;
  logic [1:0]        wb_size, wb_offset;

  // Long-latency result FIFO
  logic [DATA_W-1:0] ll_data_mem [LL_DEPTH];
  logic [ADDR_W-1:0] ll_addr_mem [LL_DEPTH];
  logic [BANK_W-1:0] ll_bank_mem [LL_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_LW-1:0] ll_count;

  logic wb_pending, wb_commit, noop_retire, ll_full, ll_empty, ll_push, ll_pop;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [BANK_W-1:0] sel_bank;
  logic [DATA_W-1:0] sel_data;

  // Select/extend a byte, half or word out of the raw load word.
  function automatic logic [DATA_W-1:0] format_load(
    input logic [DATA_W-1:0] rdata, input logic [1:0] size,
    input logic [1:0] offset, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    case (offset)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    w = rdata[31:0];
    case (size)
      2'b00:   return uns ? DATA_W'(b) : DATA_W'($signed(b));
      2'b01:   return uns ? DATA_W'(h) : DATA_W'($signed(h));
      default: return uns ? DATA_W'(w) : DATA_W'($signed(w));
    endcase
  endfunction

  assign wen_wb_o     = wb_valid & (wb_alu_wen | wb_mem_wen);
  assign wb_pending   = wen_wb_o & ~wb_committed;
  assign ll_full      = (ll_count == DEPTH_C);
  assign ll_empty     = (ll_count == '0);
  assign ll_ready_o   = ~ll_full;
  assign hold_req_o   = ll_full & wb_pending;
  assign wb_commit    = wb_pending & ~hold_req_o;
  // FIFO drains whenever the pipeline does not claim the port (incl. hold).
  assign ll_pop       = ~ll_empty & ~wb_commit;
  assign ll_push      = ll_valid_i & ll_ready_o;
  // Stores/branches retire once on arrival even though they never write.
  assign noop_retire  = wb_valid & ~(wb_alu_wen | wb_mem_wen) & ~wb_committed;
  assign retire_o     = wb_commit | noop_retire;

  assign rd_addr_wb_o = wb_rd_addr;
  assign rd_bank_wb_o = wb_rd_bank;
  assign wdata_wb_o   = wb_alu_wen ? wb_alu_result
                                   : format_load(wb_rdata, wb_size, wb_offset, wb_unsigned);
  assign ll_count_o   = ll_count;
  assign reg_waddr_o  = sel_addr;
  assign reg_wdata_o  = sel_data;

  // Write-port arbitration and one-hot bank enable (x0 of bank 0 is never written).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_bank  = '0;
    sel_data  = '0;
    reg_wen_o = '0;
    if (wb_commit) begin
      sel_write = 1'b1;
      sel_addr  = wb_rd_addr;
      sel_bank  = wb_rd_bank;
      sel_data  = wdata_wb_o;
    end else if (ll_pop) begin
      sel_write = 1'b1;
      sel_addr  = ll_addr_mem[rd_ptr];
      sel_bank  = ll_bank_mem[rd_ptr];
      sel_data  = ll_data_mem[rd_ptr];
    end
    if (sel_write && !(sel_bank == '0 && sel_addr == '0)) begin
      for (int b = 0; b < NBANKS; b++) begin
        if (sel_bank == BANK_W'(b)) reg_wen_o[b] = 1'b1;
      end
    end
  end

  // WB register: flush > hold (stall or arbitration) > load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      wb_valid      <= 1'b0;
      wb_alu_wen    <= 1'b0;
      wb_mem_wen    <= 1'b0;
      wb_unsigned   <= 1'b0;
      wb_committed  <= 1'b0;
      wb_rd_addr    <= '0;
      wb_rd_bank    <= '0;
      wb_alu_result <= '0;
      wb_rdata      <= '0;
      wb_size       <= '0;
      wb_offset     <= '0;
    end else if (flush_wb_i) begin
      wb_valid     <= 1'b0;
      wb_alu_wen   <= 1'b0;
      wb_mem_wen   <= 1'b0;
      wb_committed <= 1'b0;
    end else if (stall_wb_i || hold_req_o) begin
      wb_committed <= wb_committed | retire_o;
    end else begin
      wb_valid      <= valid_mem_i;
      wb_alu_wen    <= reg_alu_wen_mem_i;
      wb_mem_wen    <= reg_mem_wen_mem_i;
      wb_unsigned   <= mem_unsigned_mem_i;
      wb_committed  <= 1'b0;
      wb_rd_addr    <= rd_addr_mem_i;
      wb_rd_bank    <= rd_bank_mem_i;
      wb_alu_result <= alu_result_mem_i;
      wb_rdata      <= mem_rdata_mem_i;
      wb_size       <= mem_size_mem_i;
      wb_offset     <= mem_offset_mem_i;
    end
  end

  // FIFO storage: written on push only.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is not reset; the count/pointers alone define which entries are valid.
    if (ll_push) begin
      ll_data_mem[wr_ptr] <= ll_wdata_i;
      ll_addr_mem[wr_ptr] <= ll_rd_addr_i;
      ll_bank_mem[wr_ptr] <= ll_rd_bank_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ll_count <= '0;
    end else begin
      if (ll_push) wr_ptr <= wr_ptr + 1'b1;
      if (ll_pop)  rd_ptr <= rd_ptr + 1'b1;
      ll_count <= ll_count + CNT_LW'(ll_push) - CNT_LW'(ll_pop);
    end
  end

  // Retired-instruction counter, wraps at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) instret_o <= '0;
    else          instret_o <= instret_o + CNT_W'(retire_o);
  end

endmodule

// File: tb/tb_wb_stage_arb.sv
// Self-checking bench for wb_stage_arb: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_wb_stage_arb;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        rd_bank_mem_i;
  logic [31:0] alu_result_mem_i, mem_rdata_mem_i;
  logic [1:0]  mem_size_mem_i, mem_offset_mem_i;
  logic        mem_unsigned_mem_i, reg_alu_wen_mem_i, reg_mem_wen_mem_i;
  logic        stall_wb_i, flush_wb_i, ll_valid_i, ll_ready_o;
  logic [4:0]  ll_rd_addr_i;
  logic        ll_rd_bank_i;
  logic [31:0] ll_wdata_i;
  logic [1:0]  reg_wen_o;
  logic [4:0]  reg_waddr_o, rd_addr_wb_o;
  logic [31:0] reg_wdata_o, wdata_wb_o;
  logic        hold_req_o, rd_bank_wb_o, wen_wb_o, retire_o;
  logic [2:0]  ll_count_o;
  logic [63:0] instret_o;

  wb_stage_arb dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .valid_mem_i(valid_mem_i), .rd_addr_mem_i(rd_addr_mem_i), .rd_bank_mem_i(rd_bank_mem_i),
    .alu_result_mem_i(alu_result_mem_i), .mem_rdata_mem_i(mem_rdata_mem_i),
    .mem_size_mem_i(mem_size_mem_i), .mem_unsigned_mem_i(mem_unsigned_mem_i),
    .mem_offset_mem_i(mem_offset_mem_i), .reg_alu_wen_mem_i(reg_alu_wen_mem_i),
    .reg_mem_wen_mem_i(reg_mem_wen_mem_i), .stall_wb_i(stall_wb_i), .flush_wb_i(flush_wb_i),
    .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o), .ll_rd_addr_i(ll_rd_addr_i),
    .ll_rd_bank_i(ll_rd_bank_i), .ll_wdata_i(ll_wdata_i),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .hold_req_o(hold_req_o), .rd_addr_wb_o(rd_addr_wb_o), .rd_bank_wb_o(rd_bank_wb_o),
    .wdata_wb_o(wdata_wb_o), .wen_wb_o(wen_wb_o), .ll_count_o(ll_count_o),
    .retire_o(retire_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  typedef struct {
    logic valid, alu_wen, mem_wen, uns, committed;
    logic [4:0] addr;
    logic bank;
    logic [31:0] alu, rdata;
    logic [1:0] size, off;
  } wb_t;
  typedef struct { logic [4:0] addr; logic bank; logic [31:0] data; } ll_t;

  wb_t         m_wb;
  ll_t         m_q[$];
  logic [63:0] m_instret;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_wb = '{default: '0};
    m_q.delete();
    m_instret = '0;
  endtask

  // Load formatting from the data-sheet rules: shift, mask, extend.
  function automatic logic [31:0] m_fmt(input wb_t e);
    logic [31:0] v;
    if (e.alu_wen) return e.alu;
    if (e.size == 2'b00) begin
      v = (e.rdata >> (8 * e.off)) & 32'hFF;
      if (!e.uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (e.size == 2'b01) begin
      v = (e.rdata >> (e.off[1] ? 16 : 0)) & 32'hFFFF;
      if (!e.uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = e.rdata;
    end
    return v;
  endfunction

  // Compare all outputs for the current cycle, then advance the model across the edge.
  task automatic model_step();
    bit writes_e, pending, full, hold, wb_w, ll_w, ret, push, w;
    logic [4:0] a; logic bk; logic [31:0] d; logic [1:0] wen_e;
    writes_e = m_wb.valid && (m_wb.alu_wen || m_wb.mem_wen);
    pending  = writes_e && !m_wb.committed;
    full     = (m_q.size() == 4);
    hold     = full && pending;
    wb_w     = pending && !hold;
    ll_w     = !wb_w && (m_q.size() > 0);
    ret      = wb_w || (m_wb.valid && !writes_e && !m_wb.committed);
    w        = wb_w || ll_w;
    a = '0; bk = 1'b0; d = '0;
    if (wb_w)      begin a = m_wb.addr;    bk = m_wb.bank;    d = m_fmt(m_wb);  end
    else if (ll_w) begin a = m_q[0].addr;  bk = m_q[0].bank;  d = m_q[0].data;  end
    wen_e = (w && !(bk == 1'b0 && a == 5'd0)) ? (2'b01 << bk) : 2'b00;
    check("reg_wen", 64'(reg_wen_o), 64'(wen_e));
    if (w) begin
      check("reg_waddr", 64'(reg_waddr_o), 64'(a));
      check("reg_wdata", 64'(reg_wdata_o), 64'(d));
    end
    check("hold_req", 64'(hold_req_o), 64'(hold));
    check("ll_ready", 64'(ll_ready_o), 64'(!full));
    check("ll_count", 64'(ll_count_o), 64'(m_q.size()));
    check("retire", 64'(retire_o), 64'(ret));
    check("instret", instret_o, m_instret);
    check("wen_wb", 64'(wen_wb_o), 64'(writes_e));
    if (m_wb.valid) begin
      check("rd_addr_wb", 64'(rd_addr_wb_o), 64'(m_wb.addr));
      check("rd_bank_wb", 64'(rd_bank_wb_o), 64'(m_wb.bank));
      check("wdata_wb", 64'(wdata_wb_o), 64'(m_fmt(m_wb)));
    end
    // next state
    push = ll_valid_i && (m_q.size() < 4);
    if (ll_w) void'(m_q.pop_front());
    if (push) m_q.push_back('{addr: ll_rd_addr_i, bank: ll_rd_bank_i, data: ll_wdata_i});
    m_instret = m_instret + 64'(ret);
    if (flush_wb_i) begin
      m_wb.valid = 1'b0; m_wb.alu_wen = 1'b0; m_wb.mem_wen = 1'b0; m_wb.committed = 1'b0;
    end else if (stall_wb_i || hold) begin
      m_wb.committed = m_wb.committed || ret;
    end else begin
      m_wb = '{valid: valid_mem_i, alu_wen: reg_alu_wen_mem_i, mem_wen: reg_mem_wen_mem_i,
               uns: mem_unsigned_mem_i, committed: 1'b0, addr: rd_addr_mem_i,
               bank: rd_bank_mem_i, alu: alu_result_mem_i, rdata: mem_rdata_mem_i,
               size: mem_size_mem_i, off: mem_offset_mem_i};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    valid_mem_i = 0; rd_addr_mem_i = 0; rd_bank_mem_i = 0; alu_result_mem_i = 0;
    mem_rdata_mem_i = 0; mem_size_mem_i = 0; mem_offset_mem_i = 0; mem_unsigned_mem_i = 0;
    reg_alu_wen_mem_i = 0; reg_mem_wen_mem_i = 0; stall_wb_i = 0; flush_wb_i = 0;
    ll_valid_i = 0; ll_rd_addr_i = 0; ll_rd_bank_i = 0; ll_wdata_i = 0;
  endtask

  task automatic set_mem(input logic [4:0] addr, input logic bank, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [1:0] size, input logic [1:0] off,
                         input logic uns, input logic alu_wen, input logic mem_wen);
    valid_mem_i = 1; rd_addr_mem_i = addr; rd_bank_mem_i = bank; alu_result_mem_i = alu;
    mem_rdata_mem_i = rdata; mem_size_mem_i = size; mem_offset_mem_i = off;
    mem_unsigned_mem_i = uns; reg_alu_wen_mem_i = alu_wen; reg_mem_wen_mem_i = mem_wen;
  endtask

  task automatic set_ll(input logic [4:0] addr, input logic bank, input logic [31:0] data);
    ll_valid_i = 1; ll_rd_addr_i = addr; ll_rd_bank_i = bank; ll_wdata_i = data;
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    to_neg();
    finish_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes, retires;
    logic [63:0] ins_base;
    rst_n_i = 1'b0;
    idle();
    m_reset();
    to_neg();
    check("rst_ll_ready", 64'(ll_ready_o), 64'd1);
    check("rst_reg_wen", 64'(reg_wen_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    check("rst_count", 64'(ll_count_o), 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Loads: LB signed, LBU, LH at offset 2
    set_mem(5, 0, 0, 32'h80FF_FF01, 2'b00, 2'd3, 0, 0, 1); tick(); idle();
    to_neg();
    check("lb_wen", 64'(reg_wen_o), 64'd1);
    check("lb_waddr", 64'(reg_waddr_o), 64'd5);
    check("lb_wdata", 64'(reg_wdata_o), 64'hFFFF_FF80);
    finish_cycle();
    set_mem(5, 0, 0, 32'h80FF_FF01, 2'b00, 2'd3, 1, 0, 1); tick(); idle();
    to_neg(); check("lbu_wdata", 64'(reg_wdata_o), 64'h0000_0080); finish_cycle();
    set_mem(6, 0, 0, 32'h80FF_FF01, 2'b01, 2'd2, 0, 0, 1); tick(); idle();
    to_neg(); check("lh_wdata", 64'(reg_wdata_o), 64'hFFFF_80FF); finish_cycle();

    // ALU write to x0: bank 0 suppressed but retired; bank 1 written
    set_mem(0, 0, 32'hDEAD_BEEF, 0, 2'b10, 0, 0, 1, 0); tick(); idle();
    ins_base = m_instret;
    to_neg();
    check("x0_wen", 64'(reg_wen_o), 64'd0);
    check("x0_retire", 64'(retire_o), 64'd1);
    finish_cycle();
    to_neg(); check("x0_instret", instret_o, ins_base + 64'd1); finish_cycle();
    set_mem(0, 1, 32'hDEAD_BEEF, 0, 2'b10, 0, 0, 1, 0); tick(); idle();
    to_neg(); check("b1_x0_wen", 64'(reg_wen_o), 64'd2); finish_cycle();

    // Stall 3 cycles: one write, one retire; then flush during stall
    set_mem(3, 0, 32'h1111_2222, 0, 2'b10, 0, 0, 1, 0); tick(); idle();
    stall_wb_i = 1; writes = 0; retires = 0;
    repeat (3) begin
      to_neg();
      writes += (reg_wen_o != 0) ? 1 : 0;
      retires += retire_o ? 1 : 0;
      finish_cycle();
    end
    check("stall_writes", 64'(writes), 64'd1);
    check("stall_retires", 64'(retires), 64'd1);
    flush_wb_i = 1; tick(); flush_wb_i = 0;
    to_neg();
    check("flush_wen_wb", 64'(wen_wb_o), 64'd0);
    check("flush_reg_wen", 64'(reg_wen_o), 64'd0);
    finish_cycle();
    idle(); tick();

    // Fill FIFO while the pipeline writes every cycle, then arbitration hold
    set_mem(10, 0, 32'hA0, 0, 2'b10, 0, 0, 1, 0); tick();
    for (int i = 1; i <= 4; i++) begin
      set_mem(5'(10 + i), 0, 32'(32'hA0 + i), 0, 2'b10, 0, 0, 1, 0);
      set_ll(5'(20 + i), 0, 32'(32'hC0 + i));
      tick();
    end
    idle();
    to_neg();
    check("full_ready", 64'(ll_ready_o), 64'd0);
    check("full_count", 64'(ll_count_o), 64'd4);
    check("hold_req", 64'(hold_req_o), 64'd1);
    check("hold_waddr", 64'(reg_waddr_o), 64'd21);
    check("hold_wdata", 64'(reg_wdata_o), 64'hC1);
    finish_cycle();
    to_neg();
    check("after_hold_req", 64'(hold_req_o), 64'd0);
    check("after_hold_waddr", 64'(reg_waddr_o), 64'd14);
    check("after_hold_wdata", 64'(reg_wdata_o), 64'hA4);
    check("after_hold_count", 64'(ll_count_o), 64'd3);
    finish_cycle();
    repeat (5) tick();

    // Idle pipeline, single LL push
    set_ll(7, 1, 32'h1234);
    to_neg(); check("ll_cnt0", 64'(ll_count_o), 64'd0); finish_cycle();
    idle();
    to_neg();
    check("ll_wen", 64'(reg_wen_o), 64'd2);
    check("ll_waddr", 64'(reg_waddr_o), 64'd7);
    check("ll_wdata", 64'(reg_wdata_o), 64'h1234);
    check("ll_cnt1", 64'(ll_count_o), 64'd1);
    finish_cycle();
    to_neg(); check("ll_cnt_drained", 64'(ll_count_o), 64'd0); finish_cycle();

    // Randomized traffic
    repeat (400) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_mem(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      stall_wb_i = ($urandom_range(0, 3) == 0);
      flush_wb_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1)
        set_ll(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      tick();
    end

    // Reset mid-operation with 3 FIFO entries and a valid WB entry
    idle(); repeat (6) tick();
    set_mem(8, 0, 32'h55, 0, 2'b10, 0, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_mem(5'(8 + i), 0, 32'h55, 0, 2'b10, 0, 0, 1, 0);
      set_ll(5'(16 + i), 1, 32'(32'h900 + i));
      tick();
    end
    idle();
    to_neg();
    check("pre_rst_count", 64'(ll_count_o), 64'd3);
    check("pre_rst_wen_wb", 64'(wen_wb_o), 64'd1);
    #1 rst_n_i = 1'b0;
    #1;
    m_reset();
    check("rst_reg_wen_mid", 64'(reg_wen_o), 64'd0);
    check("rst_waddr_mid", 64'(reg_waddr_o), 64'd0);
    check("rst_wdata_mid", 64'(reg_wdata_o), 64'd0);
    check("rst_hold_mid", 64'(hold_req_o), 64'd0);
    check("rst_fwd_addr_mid", 64'(rd_addr_wb_o), 64'd0);
    check("rst_fwd_bank_mid", 64'(rd_bank_wb_o), 64'd0);
    check("rst_fwd_data_mid", 64'(wdata_wb_o), 64'd0);
    check("rst_wen_wb_mid", 64'(wen_wb_o), 64'd0);
    check("rst_count_mid", 64'(ll_count_o), 64'd0);
    check("rst_retire_mid", 64'(retire_o), 64'd0);
    check("rst_instret_mid", instret_o, 64'd0);
    check("rst_ready_mid", 64'(ll_ready_o), 64'd1);
    @(posedge clk_i); #1;
    to_neg();
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (4) begin
      to_neg();
      check("post_rst_wen", 64'(reg_wen_o), 64'd0);
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_arb.md
Name: wb_stage_arb

Overview:
- Parametrised write-back stage with a MEM->WB pipeline register, load-data formatting, and NBANKS register-bank write enables.
- A single register-file write port is shared between the in-order pipeline and a buffered long-latency result port (divider/FPU), with arbitration and back-pressure.
- Provides forwarding outputs and an instruction-retire counter.
- Sits between the MEM stage and the register banks.

Parameters:
DATA_W, 32, datapath width (≥32, multiple of 8)
ADDR_W, 5, register address width
NBANKS, 2, register banks (bank 0 = X, address 0 hard-wired zero)
LL_DEPTH, 4, long-latency result FIFO depth (power of 2, ≥2)
CNT_W, 64, retire counter width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  async active-low reset
valid_mem_i  in  1  MEM entry valid
rd_addr_mem_i  in  ADDR_W  destination register
rd_bank_mem_i  in  $clog2(NBANKS)  destination bank
alu_result_mem_i  in  DATA_W  ALU result
mem_rdata_mem_i  in  DATA_W  raw load word
mem_size_mem_i  in  2  00 byte, 01 half, 10 word
mem_unsigned_mem_i  in  1  zero-extend load
mem_offset_mem_i  in  2  load byte offset
reg_alu_wen_mem_i  in  1  write ALU result
reg_mem_wen_mem_i  in  1  write load data
stall_wb_i  in  1  hold WB register
flush_wb_i  in  1  bubble WB register
ll_valid_i  in  1  long-latency result valid
ll_ready_o  out  1  FIFO not full
ll_rd_addr_i  in  ADDR_W  LL destination
ll_rd_bank_i  in  $clog2(NBANKS)  LL bank
ll_wdata_i  in  DATA_W  LL data
reg_wen_o  out  NBANKS  one-hot bank write enable
reg_waddr_o  out  ADDR_W  write address
reg_wdata_o  out  DATA_W  write data
hold_req_o  out  1  upstream must freeze MEM
rd_addr_wb_o  out  ADDR_W  forwarding address
rd_bank_wb_o  out  $clog2(NBANKS)  forwarding bank
wdata_wb_o  out  DATA_W  formatted forwarding data
wen_wb_o  out  1  WB entry will/did write
ll_count_o  out  $clog2(LL_DEPTH)+1  FIFO occupancy
retire_o  out  1  pipeline instruction retired this cycle
instret_o  out  CNT_W  retire counter

Behaviour:
- Reset: all registers, outputs, and counters are 0; FIFO is empty; ll_ready_o=1.
- WB register load priority: flush_wb_i > (stall_wb_i | hold_req_o) > load.
  - Flush clears valid and both wens; other fields don't care.
  - Hold keeps all fields.
  - Load captures all MEM inputs and clears the committed flag.
- Commit: the WB entry commits in the first cycle where valid, (alu_wen|mem_wen), !committed, and !hold_req_o. It then sets committed, which suppresses rewrite and re-retire while stalled.
- Formatted data:
  - alu_wen selects the ALU result.
  - Otherwise byte = rdata[8*offset +: 8], half = rdata[16*offset[1] +: 16], word = rdata[31:0].
  - Sign- or zero-extend to DATA_W per mem_unsigned.
  - Offset bit 0 is ignored for halves; offset is ignored for words.
- LL FIFO:
  - Push on ll_valid_i & ll_ready_o; ll_ready_o = (count < LL_DEPTH).
  - Push and pop in the same cycle is allowed when full or empty-with-bypass is not needed (no bypass: a push lands first, a pop needs count>0).
  - Pointers wrap modulo LL_DEPTH.
- Arbitration for the single write port, per cycle:
  - hold_req_o = FIFO full & WB entry pending commit. In that cycle the FIFO head writes and pops, and the WB entry waits.
  - Else a pending WB entry writes.
  - Else, if the FIFO is non-empty, the head writes and pops.
  - Else no write.
- Write suppression: a write to bank 0, address 0 drives reg_wen_o=0 but still counts as commit/pop.
- reg_wen_o is combinational, one-hot at the selected bank.
- retire_o pulses for 1 cycle on a pipeline commit. It also pulses when a valid entry with no wens first enters WB (stores/branches), once.
- instret_o increments on retire_o and wraps at 2^CNT_W.
- Forwarding: rd_*_wb_o reflect the WB register. wdata_wb_o is the formatted data. wen_wb_o = valid & (alu_wen|mem_wen), independent of committed/hold.
- Reset mid-operation drops all FIFO contents and the WB entry.

Test Plan:
- LB at offset 3, rdata=0x80FF_FF01, signed, rd=x5 -> reg_wen_o[0]=1, waddr=5, wdata=0xFFFF_FF80; LBU -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF.
- ALU write to x0, bank 0 -> reg_wen_o=0, retire_o=1, instret +1; the same to bank 1, addr 0 -> reg_wen_o=2'b10.
- Stall_wb_i held 3 cycles with a valid ALU entry -> exactly one write and one retire; flush during stall -> bubble, no further write.
- Push 4 LL results while the pipeline writes every cycle -> ll_ready_o=0 after the 4th; next pending WB entry -> hold_req_o=1, LL head written and popped, the WB entry written the following cycle.
- Idle pipeline, LL push of 0x1234 to bank 1, r7 -> written the cycle after the push, ll_count_o 1->0.
- Assert rst_n_i low with 3 FIFO entries and a valid WB entry -> all outputs 0 immediately, ll_ready_o=1, no writes after release.
